cordic_vec_arbiter: RTL and testbench

- Round-robin scheduler that shares one pipelined vector-mode CORDIC (magnitude/phase engine) between NCH requesters.
- Accepts (x,y) samples from each channel over valid/ready, issues at most one per cycle into the CORDIC, and queues the channel ID in an in-order tag FIFO.
- Returns each result tagged with its originating channel.
- Sits between the per-channel I/Q front ends and the demod back end.

---
 rtl/cordic_vec_arbiter.sv | 136 +++++++++++++
 tb/tb_cordic_vec_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_arbiter.sv
// Round-robin arbiter sharing one pipelined vector-mode CORDIC among NCH channels.
// Channel IDs ride alongside the CORDIC in an in-order tag FIFO so results come back tagged.
module cordic_vec_arbiter #(
    parameter int NCH       = 4,
    parameter int XY_BITS   = 12,
    parameter int PH_BITS   = 32,
    parameter int TAG_DEPTH = 64,
    parameter int CHW       = $clog2(NCH)
) (
    input  logic                                 clk_in,
    input  logic                                 RST,
    input  logic                                 en,
    input  logic [NCH-1:0]                       req_valid,
    input  logic [NCH*XY_BITS-1:0]               req_x,
    input  logic [NCH*XY_BITS-1:0]               req_y,
    output logic [NCH-1:0]                       req_ready,
    output logic [XY_BITS-1:0]                   cor_x,
    output logic [XY_BITS-1:0]                   cor_y,
    output logic                                 cor_valid_in,
    input  logic                                 cor_valid_out,
    input  logic [PH_BITS-1:0]                   cor_phase,
    input  logic [XY_BITS:0]                     cor_mag,
    output logic                                 res_valid,
    output logic [CHW-1:0]                       res_ch,
    output logic [XY_BITS:0]                     res_mag,
    output logic [PH_BITS-1:0]                   res_phase,
    output logic [$clog2(TAG_DEPTH+1)-1:0]       in_flight,
    output logic                                 err_underflow,
    output logic                                 err_overrun
);

    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam int AW = $clog2(TAG_DEPTH);

    logic [CHW-1:0]     r_ptr;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CHW-1:0]     r_tags [TAG_DEPTH];
    logic [XY_BITS-1:0] r_cor_x;
    logic [XY_BITS-1:0] r_cor_y;
    logic               r_cor_valid;
    logic               r_res_valid;
    logic [CHW-1:0]     r_res_ch;
    logic [XY_BITS:0]   r_res_mag;
    logic [PH_BITS-1:0] r_res_phase;
    logic               r_err_underflow;
    logic               r_err_overrun;

    logic               w_eligible;
    logic               w_grant_any;
    logic [CHW-1:0]     w_grant_ch;
    logic               w_pop;
    logic [CHW-1:0]     w_ptr_next;

    // Full blocks grants even when a pop lands in the same cycle: keeps pop off the ready path.
    assign w_eligible = en && !RST && (r_count < CW'(TAG_DEPTH));
    assign w_pop      = cor_valid_out && (r_count != '0);
    assign w_ptr_next = (w_grant_ch == CHW'(NCH - 1)) ? '0 : w_grant_ch + CHW'(1);

    always_comb begin
        logic [CHW-1:0] c;
        w_grant_any = 1'b0;
        w_grant_ch  = '0;
        c           = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            c = CHW'((32'(r_ptr) + i) % NCH);
            if (w_eligible && !w_grant_any && req_valid[c]) begin
                w_grant_any = 1'b1;
                w_grant_ch  = c;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_any) req_ready[w_grant_ch] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            r_ptr           <= '0;
            r_count         <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cor_x         <= '0;
            r_cor_y         <= '0;
            r_cor_valid     <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_ch        <= '0;
            r_res_mag       <= '0;
            r_res_phase     <= '0;
            r_err_underflow <= 1'b0;
            r_err_overrun   <= 1'b0;
        end else begin
            r_cor_valid <= w_grant_any;
            if (w_grant_any) begin
                r_ptr    <= w_ptr_next;
                r_cor_x  <= req_x[w_grant_ch*XY_BITS +: XY_BITS];
                r_cor_y  <= req_y[w_grant_ch*XY_BITS +: XY_BITS];
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_res_valid <= w_pop;
            if (w_pop) begin
                r_res_ch    <= r_tags[r_rd_ptr];
                r_res_mag   <= cor_mag;
                r_res_phase <= cor_phase;
                r_rd_ptr    <= r_rd_ptr + AW'(1);
            end
            if (cor_valid_out && (r_count == '0)) r_err_underflow <= 1'b1;
            if (w_grant_any && (r_count == CW'(TAG_DEPTH))) r_err_overrun <= 1'b1;
            case ({w_grant_any, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_in) begin
        if (w_grant_any) r_tags[r_wr_ptr] <= w_grant_ch;
    end

    assign cor_x         = r_cor_x;
    assign cor_y         = r_cor_y;
    assign cor_valid_in  = r_cor_valid;
    assign res_valid     = r_res_valid;
    assign res_ch        = r_res_ch;
    assign res_mag       = r_res_mag;
    assign res_phase     = r_res_phase;
    assign in_flight     = r_count;
    assign err_underflow = r_err_underflow;
    assign err_overrun   = r_err_overrun;

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// Randomized bench for cordic_vec_arbiter with a queue-based reference model and a
// behavioural CORDIC stand-in (fixed latency, stallable, mag=|x|+|y|).
module tb_cordic_vec_arbiter;

    localparam int NCH = 4, XY = 12, PH = 32, TD = 64, LAT = 34;
    localparam int CHW = $clog2(NCH);
    localparam int CW = $clog2(TD + 1);

    logic                clk_in = 1'b0;
    logic                RST;
    logic                en;
    logic [NCH-1:0]      req_valid;
    logic [NCH*XY-1:0]   req_x, req_y;
    logic [NCH-1:0]      req_ready;
    logic [XY-1:0]       cor_x, cor_y;
    logic                cor_valid_in;
    logic                cor_valid_out;
    logic [PH-1:0]       cor_phase;
    logic [XY:0]         cor_mag;
    logic                res_valid;
    logic [CHW-1:0]      res_ch;
    logic [XY:0]         res_mag;
    logic [PH-1:0]       res_phase;
    logic [CW-1:0]       in_flight;
    logic                err_underflow, err_overrun;

    cordic_vec_arbiter #(.NCH(NCH), .XY_BITS(XY), .PH_BITS(PH), .TAG_DEPTH(TD)) dut (
        .clk_in(clk_in), .RST(RST), .en(en), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_ready(req_ready), .cor_x(cor_x), .cor_y(cor_y),
        .cor_valid_in(cor_valid_in), .cor_valid_out(cor_valid_out), .cor_phase(cor_phase),
        .cor_mag(cor_mag), .res_valid(res_valid), .res_ch(res_ch), .res_mag(res_mag),
        .res_phase(res_phase), .in_flight(in_flight), .err_underflow(err_underflow),
        .err_overrun(err_overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [XY-1:0] x; logic [XY-1:0] y; int due; } ent_t;

    int checks = 0, failures = 0, cyc = 0;
    int m_ptr = 0;
    int m_tags[$];
    ent_t cq[$];
    logic stall = 1'b0, rel1 = 1'b0;
    logic e_cv = 0, e_rv = 0, e_unf = 0;
    logic [XY-1:0] e_x = '0, e_y = '0;
    logic [CHW-1:0] e_ch = '0;
    logic [XY:0] e_mag = '0;
    logic [PH-1:0] e_ph = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_ch(input int c, input logic [XY-1:0] x, input logic [XY-1:0] y);
        req_x[c*XY +: XY] = x;
        req_y[c*XY +: XY] = y;
    endtask

    // One clock: predict grant, clock, update model, compare, then step the CORDIC stand-in.
    task automatic tick();
        int g;
        logic [NCH-1:0] exp_rdy;
        logic cv;
        logic [XY:0] cm;
        logic [PH-1:0] cp;
        logic [XY-1:0] gx, gy;
        ent_t e;
        int ax, ay;
        #2;
        g = -1;
        if (en && !RST && m_tags.size() < TD)
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_ptr + i) % NCH;
                if (g < 0 && req_valid[c]) g = c;
            end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        cv = cor_valid_out; cm = cor_mag; cp = cor_phase;
        gx = '0; gy = '0;
        if (g >= 0) begin gx = req_x[g*XY +: XY]; gy = req_y[g*XY +: XY]; end
        @(posedge clk_in);
        #1;
        cyc++;
        if (RST) begin
            m_tags.delete(); cq.delete(); m_ptr = 0;
            e_cv = 0; e_rv = 0; e_unf = 0; e_x = '0; e_y = '0;
            e_ch = '0; e_mag = '0; e_ph = '0;
        end else begin
            e_rv = 1'b0;
            if (cv) begin
                if (m_tags.size() > 0) begin
                    e_rv = 1'b1; e_ch = CHW'(m_tags.pop_front()); e_mag = cm; e_ph = cp;
                end else e_unf = 1'b1;
            end
            e_cv = (g >= 0);
            if (g >= 0) begin
                m_tags.push_back(g); m_ptr = (g + 1) % NCH; e_x = gx; e_y = gy;
            end
        end
        chk("cor_valid_in", 64'(cor_valid_in), 64'(e_cv));
        chk("cor_x", 64'(cor_x), 64'(e_x));
        chk("cor_y", 64'(cor_y), 64'(e_y));
        chk("res_valid", 64'(res_valid), 64'(e_rv));
        chk("res_ch", 64'(res_ch), 64'(e_ch));
        chk("res_mag", 64'(res_mag), 64'(e_mag));
        chk("res_phase", 64'(res_phase), 64'(e_ph));
        chk("in_flight", 64'(in_flight), 64'(m_tags.size()));
        chk("err_underflow", 64'(err_underflow), 64'(e_unf));
        chk("err_overrun", 64'(err_overrun), 64'd0);
        if (!RST && cor_valid_in) cq.push_back('{x: cor_x, y: cor_y, due: cyc + LAT - 1});
        cor_valid_out = 1'b0;
        if (!RST && (!stall || rel1) && cq.size() > 0 && cq[0].due <= cyc) begin
            e = cq.pop_front();
            ax = $signed(e.x); if (ax < 0) ax = -ax;
            ay = $signed(e.y); if (ay < 0) ay = -ay;
            cor_valid_out = 1'b1;
            cor_mag = (XY+1)'(ax + ay);
            cor_phase = {8'h5A, e.x, e.y};
            rel1 = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        req_valid = '0;
        for (int i = 0; i < budget && (in_flight != '0 || cq.size() > 0); i++) tick();
        chk("drain_in_flight", 64'(in_flight), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; en = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
        cor_valid_out = 1'b0; cor_mag = '0; cor_phase = '0;
        tick(); tick();
        RST = 1'b0; en = 1'b1;

        // Round-robin fairness from pointer 0
        for (int c = 0; c < NCH; c++) set_ch(c, XY'(16 * c + 1), XY'(-(c + 3)));
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            #2; chk("rr_order", 64'(req_ready), 64'(1) << (i % NCH));
            tick();
        end
        chk("rr_peak", 64'(in_flight <= CW'(12)), 64'd1);
        drain(200);

        // Single channel 2, x=100 y=0 (pointer is 0 here)
        set_ch(2, XY'(100), XY'(0));
        req_valid = 4'b0100;
        #2; chk("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        chk("single_cor_x", 64'(cor_x), 64'd100);
        for (int i = 0; i < 60 && !res_valid; i++) tick();
        chk("single_res_valid", 64'(res_valid), 64'd1);
        chk("single_res_ch", 64'(res_ch), 64'd2);
        chk("single_res_mag", 64'(res_mag), 64'd100);
        drain(100);

        // Pointer now 3: grant ch1 alone moves it to 2, then ch1+ch3 -> ch3, ch1
        req_valid = 4'b0010; tick();
        req_valid = 4'b1010;
        #2; chk("mix_first", 64'(req_ready), 64'b1000);
        tick();
        #2; chk("mix_second", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        drain(100);

        // Random traffic with en toggling and CORDIC stalls
        for (int i = 0; i < 1500; i++) begin
            req_valid = NCH'($urandom);
            req_x = (NCH*XY)'({$urandom, $urandom});
            req_y = (NCH*XY)'({$urandom, $urandom});
            en = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        stall = 1'b0; en = 1'b1;
        drain(400);

        // FIFO full with the CORDIC stalled
        stall = 1'b1; req_valid = '1;
        for (int i = 0; i < 70; i++) tick();
        chk("full_in_flight", 64'(in_flight), 64'(TD));
        #2; chk("full_ready", 64'(req_ready), 64'd0);
        rel1 = 1'b1;
        tick();
        tick();
        chk("full_pop", 64'(in_flight), 64'(TD - 1));
        #2; chk("resume_ready", 64'(|req_ready), 64'd1);
        tick();
        chk("refill", 64'(in_flight), 64'(TD));
        stall = 1'b0; req_valid = '0;
        drain(400);
        chk("no_overrun", 64'(err_overrun), 64'd0);

        // Underflow: result with empty FIFO
        cor_valid_out = 1'b1; cor_mag = 13'h1AB; cor_phase = 32'hDEAD_BEEF;
        tick();
        chk("unf_flag", 64'(err_underflow), 64'd1);
        chk("unf_res", 64'(res_valid), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("unf_sticky", 64'(err_underflow), 64'd1);

        // Reset mid-stream with 10 samples in flight
        req_valid = '1;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_in_flight", 64'(in_flight), 64'd10);
        req_valid = '0; RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_in_flight", 64'(in_flight), 64'd0);
        chk("rst_unf", 64'(err_underflow), 64'd0);
        for (int i = 0; i < 50; i++) tick();
        set_ch(0, XY'(-7), XY'(5));
        req_valid = 4'b1111;
        #2; chk("rst_ptr", 64'(req_ready), 64'b0001);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        for (int i = 0; i < 60 && !res_valid; i++) tick();
        chk("post_rst_res", 64'(res_valid), 64'd1);
        chk("post_rst_ch", 64'(res_ch), 64'd0);
        chk("post_rst_mag", 64'(res_mag), 64'd12);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
